// File: rtl/rl_env_pkg.sv
// Shared types and constants for the grid environment and the Q-learning agent.
// Actions, FSM states, datapath widths and the default reward table.
package rl_env_pkg;

    localparam int STATE_W  = 6;
    localparam int REWARD_W = 16;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_RIGHT = 2'd1;
    localparam logic [1:0] ACT_DOWN  = 2'd2;
    localparam logic [1:0] ACT_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } env_state_t;

    // Signed Q8.8
    localparam logic [REWARD_W-1:0] R_GOAL_DEF = 16'h0100;
    localparam logic [REWARD_W-1:0] R_STEP_DEF = 16'hFFF0;
    localparam logic [REWARD_W-1:0] R_WALL_DEF = 16'hFF00;

endpackage

// File: rtl/grid_move_calc.sv
// Combinational move resolver: target cell of an action and whether it is legal.
// Edges do not wrap; reserved action bits count as a blocked move.
module grid_move_calc
    import rl_env_pkg::*;
#(
    parameter int                 GRID_W     = 8,
    parameter int                 GRID_H     = 8,
    parameter logic [STATE_W-1:0] GOAL_STATE = 6'd63
) (
    input  logic [STATE_W-1:0] state,
    input  logic [3:0]         action,
    input  logic [63:0]        obstacle_map,
    output logic [STATE_W-1:0] target,
    output logic               blocked,
    output logic               at_goal
);

    localparam logic [STATE_W-1:0] W    = STATE_W'(GRID_W);
    localparam logic [STATE_W-1:0] W_M1 = STATE_W'(GRID_W - 1);
    localparam logic [STATE_W-1:0] H_M1 = STATE_W'(GRID_H - 1);
    localparam logic [STATE_W-1:0] ONE  = STATE_W'(1);

    logic [STATE_W-1:0] row;
    logic [STATE_W-1:0] col;
    logic               off_grid;

    assign row = state / W;
    assign col = state % W;

    always_comb begin
        target   = state;
        off_grid = 1'b0;
        case (action[1:0])
            ACT_UP: begin
                off_grid = (row == '0);
                target   = state - W;
            end
            ACT_RIGHT: begin
                off_grid = (col == W_M1);
                target   = state + ONE;
            end
            ACT_DOWN: begin
                off_grid = (row == H_M1);
                target   = state + W;
            end
            ACT_LEFT: begin
                off_grid = (col == '0);
                target   = state - ONE;
            end
            default: ;
        endcase
    end

    // target is meaningless when off_grid, but blocked already covers that case
    assign blocked = (action[3:2] != 2'b00) | off_grid | obstacle_map[target];
    assign at_goal = ~blocked & (target == GOAL_STATE);

endmodule

// File: rtl/grid_env_stepper.sv
// Grid-world environment stepper closing the loop with the Q-learning agent.
// Applies accepted actions, issues rewards, and restarts episodes on goal/timeout.
module grid_env_stepper
    import rl_env_pkg::*;
#(
    parameter int                  GRID_W      = 8,
    parameter int                  GRID_H      = 8,
    parameter logic [STATE_W-1:0]  START_STATE = 6'd0,
    parameter logic [STATE_W-1:0]  GOAL_STATE  = 6'd63,
    parameter logic [7:0]          MAX_STEPS   = 8'd200,
    parameter logic [REWARD_W-1:0] R_GOAL      = R_GOAL_DEF,
    parameter logic [REWARD_W-1:0] R_STEP      = R_STEP_DEF,
    parameter logic [REWARD_W-1:0] R_WALL      = R_WALL_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                start,
    input  logic [63:0]         obstacle_map,
    input  logic                action_valid,
    input  logic [3:0]          action,
    output logic                action_ready,
    output logic [STATE_W-1:0]  next_state,
    output logic [REWARD_W-1:0] next_reward,
    output logic                state_valid,
    output logic                episode_done,
    output logic                timeout,
    output logic [7:0]          step_count,
    output logic [15:0]         episode_count
);

    env_state_t          fsm;
    env_state_t          fsm_nxt;
    logic [STATE_W-1:0]  state_d;
    logic [REWARD_W-1:0] reward_d;
    logic                valid_d;
    logic                done_d;
    logic                timeout_d;
    logic [7:0]          steps_d;
    logic [15:0]         episodes_d;

    logic [STATE_W-1:0]  target;
    logic                blocked;
    logic                at_goal;
    logic                accept;

    grid_move_calc #(
        .GRID_W     (GRID_W),
        .GRID_H     (GRID_H),
        .GOAL_STATE (GOAL_STATE)
    ) u_move (
        .state        (next_state),
        .action       (action),
        .obstacle_map (obstacle_map),
        .target       (target),
        .blocked      (blocked),
        .at_goal      (at_goal)
    );

    assign action_ready = (fsm == RUN);
    assign accept       = action_valid & action_ready;

    always_comb begin
        fsm_nxt    = fsm;
        state_d    = next_state;
        reward_d   = next_reward;
        steps_d    = step_count;
        episodes_d = episode_count;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        if (en) begin
            // start overrides everything, including an action in the same cycle
            if (start) begin
                fsm_nxt  = RUN;
                state_d  = START_STATE;
                reward_d = '0;
                steps_d  = '0;
                valid_d  = 1'b1;
            end else begin
                case (fsm)
                    IDLE: ;
                    RUN: begin
                        if (accept) begin
                            valid_d = 1'b1;
                            steps_d = step_count + 8'd1;
                            if (blocked) begin
                                reward_d = R_WALL;
                            end else begin
                                state_d  = target;
                                reward_d = at_goal ? R_GOAL : R_STEP;
                            end
                            if (at_goal) begin
                                done_d  = 1'b1;
                                fsm_nxt = DONE;
                            end else if (steps_d == MAX_STEPS) begin
                                done_d    = 1'b1;
                                timeout_d = 1'b1;
                                fsm_nxt   = DONE;
                            end
                        end
                    end
                    DONE: begin
                        fsm_nxt    = RUN;
                        episodes_d = episode_count + 16'd1;
                        state_d    = START_STATE;
                        reward_d   = '0;
                        steps_d    = '0;
                        valid_d    = 1'b1;
                    end
                    default: fsm_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm           <= IDLE;
            next_state    <= START_STATE;
            next_reward   <= '0;
            state_valid   <= 1'b0;
            episode_done  <= 1'b0;
            timeout       <= 1'b0;
            step_count    <= '0;
            episode_count <= '0;
        end else begin
            fsm           <= fsm_nxt;
            next_state    <= state_d;
            next_reward   <= reward_d;
            state_valid   <= valid_d;
            episode_done  <= done_d;
            timeout       <= timeout_d;
            step_count    <= steps_d;
            episode_count <= episodes_d;
        end
    end

endmodule
